// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM round-robin arbiter.
package ram_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NUM_PORTS_DEFAULT = 4;
  localparam int IDX_W             = $clog2(NUM_PORTS_DEFAULT);

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... wrapping.
module ram_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM, with a bounded lock for atomic
// read-modify-write sequences. Grant is combinational; responses return one cycle later.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  lock_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic                                  ram_en_o,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_o,
  output logic                                  ram_we_o,
  output logic [DATA_WIDTH/8-1:0]               ram_be_o,
  output logic [DATA_WIDTH-1:0]                 ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 ram_rdata_i
);

  localparam int IW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LCW     = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [IW-1:0]        rsp_idx_q, rsp_idx_d;

  logic [NUM_PORTS-1:0] pick_req;
  logic [IW-1:0]        pick_ptr;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;

  // While locked, everyone but the owner is masked out, even if the owner is idle.
  always_comb begin
    pick_req = req_i;
    pick_ptr = rr_q;
    if (state_q == LOCKED) begin
      pick_req          = '0;
      pick_req[owner_q] = req_i[owner_q];
      pick_ptr          = owner_q;
    end
  end

  ram_arb_rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req_i (pick_req),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rvalid_d   = pick_gnt;
    rsp_idx_d  = pick_vld ? pick_idx : rsp_idx_q;
    case (state_q)
      ARB: begin
        if (pick_vld) begin
          if (LOCK_EN && lock_i[pick_idx]) begin
            state_d    = LOCKED;
            owner_d    = pick_idx;
            lock_cnt_d = LCW'(1);
          end else begin
            rr_d = IW'(rr_next(int'(pick_idx), NUM_PORTS));
          end
        end
      end
      LOCKED: begin
        // Release on idle owner, dropped lock, or when the grant budget is used up.
        if (!pick_vld || !lock_i[owner_q] || (int'(lock_cnt_q) + 1 >= MAX_LOCK)) begin
          state_d    = ARB;
          rr_d       = IW'(rr_next(int'(owner_q), NUM_PORTS));
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_q       <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rsp_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rsp_idx_q  <= rsp_idx_d;
    end
  end

  always_comb begin
    gnt_o       = pick_gnt;
    ram_en_o    = pick_vld;
    ram_addr_o  = pick_vld ? addr_i[pick_idx]  : '0;
    ram_we_o    = pick_vld ? we_i[pick_idx]    : 1'b0;
    ram_be_o    = pick_vld ? be_i[pick_idx]    : '0;
    ram_wdata_o = pick_vld ? wdata_i[pick_idx] : '0;
    rvalid_o    = rvalid_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rdata_o[k] = (IW'(k) == rsp_idx_q) ? ram_rdata_i : '0;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a small behavioural RAM on the far side.
module tb_ram_rr_arbiter;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req, lock, gnt, rvalid, we;
  logic [3:0][31:0]  addr, wdata, rdata;
  logic [3:0][3:0]   be;
  logic              ram_en, ram_we;
  logic [31:0]       ram_addr, ram_wdata, ram_rdata;
  logic [3:0]        ram_be;
  logic [31:0]       mem [0:255];
  logic [3:0]        pend;
  int                n_tests, n_fail, proto_err;

  ram_rr_arbiter #(
    .NUM_PORTS (4), .ADDR_WIDTH (32), .DATA_WIDTH (32), .MAX_LOCK (4)
  ) dut (
    .clk (clk), .rst_n (rst_n), .req_i (req), .lock_i (lock), .gnt_o (gnt),
    .rvalid_o (rvalid), .addr_i (addr), .we_i (we), .be_i (be), .wdata_i (wdata),
    .rdata_o (rdata), .ram_en_o (ram_en), .ram_addr_o (ram_addr), .ram_we_o (ram_we),
    .ram_be_o (ram_be), .ram_wdata_o (ram_wdata), .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  // A request still pending from the previous edge must not have been withdrawn.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else begin
      if (|(pend & ~req)) proto_err = proto_err + 1;
      pend <= req & ~gnt;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg,
                       input string tag);
    req  = r;
    lock = l;
    #2;
    chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
    @(posedge clk); #1;
    chk({tag, "_rv"}, 64'(rvalid), 64'(eg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; proto_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_rdata = '0;
    rst_n = 1'b0; req = '0; lock = '0; we = '0; be = '0; addr = '0; wdata = '0;

    #3;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_ram_en", 64'(ram_en), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_ram_addr", 64'(ram_addr), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single read on port 1
    addr[1] = 32'h10;
    req = 4'b0010;
    #2;
    chk("rd1_gnt", 64'(gnt), 64'h2);
    chk("rd1_ram_en", 64'(ram_en), 64'h1);
    chk("rd1_ram_addr", 64'(ram_addr), 64'h10);
    @(posedge clk); #1;
    chk("rd1_rv", 64'(rvalid), 64'h2);
    drive(4'b1000, 4'b0000, 4'b1000, "p3_only");

    // full rotation, then drain the still-pending requests
    for (int i = 0; i < 8; i++)
      drive(4'b1111, 4'b0000, 4'(1 << (i % 4)), $sformatf("rot%0d", i));
    drive(4'b0111, 4'b0000, 4'b0001, "drain0");
    drive(4'b0110, 4'b0000, 4'b0010, "drain1");
    drive(4'b0100, 4'b0000, 4'b0100, "drain2");

    // port 2 writes, port 0 reads back
    we[2] = 1'b1; be[2] = 4'hf; addr[2] = 32'h40; wdata[2] = 32'hDEADBEEF;
    req = 4'b0100; lock = '0;
    #2;
    chk("wr_gnt", 64'(gnt), 64'h4);
    chk("wr_ram_we", 64'(ram_we), 64'h1);
    chk("wr_ram_addr", 64'(ram_addr), 64'h40);
    chk("wr_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    chk("wr_ram_be", 64'(ram_be), 64'hf);
    @(posedge clk); #1;
    chk("wr_rv", 64'(rvalid), 64'h4);
    we[2] = 1'b0;
    addr[0] = 32'h40;
    drive(4'b0001, 4'b0000, 4'b0001, "rd0");
    chk("rd0_rdata0", 64'(rdata[0]), 64'hDEADBEEF);
    chk("rd0_rdata2", 64'(rdata[2]), 64'h0);

    // port 1 lock with forced release after four grants
    for (int i = 0; i < 4; i++)
      drive(4'b1111, 4'b0010, 4'b0010, $sformatf("lock%0d", i));
    drive(4'b1111, 4'b0010, 4'b0100, "lock_rel_p2");
    drive(4'b1111, 4'b0010, 4'b1000, "lock_rel_p3");
    drive(4'b0111, 4'b0000, 4'b0001, "ldrain0");
    drive(4'b0110, 4'b0000, 4'b0010, "ldrain1");
    drive(4'b0100, 4'b0000, 4'b0100, "ldrain2");

    // port 3 locks, then goes idle for a cycle while port 0 waits
    drive(4'b1000, 4'b1000, 4'b1000, "p3_lock");
    drive(4'b0001, 4'b1000, 4'b0000, "p3_idle");
    drive(4'b0001, 4'b0000, 4'b0001, "p0_after_rel");

    // reset while port 2 holds the lock, with a response in flight
    drive(4'b0100, 4'b0100, 4'b0100, "p2_lock");
    req = 4'b0101; lock = 4'b0100;
    #2;
    chk("p2_lock2_gnt", 64'(gnt), 64'h4);
    #2;
    rst_n = 1'b0; req = '0; lock = '0;
    #1;
    chk("rst_async_rv", 64'(rvalid), 64'h0);
    @(posedge clk); #1;
    chk("rst_hold_rv", 64'(rvalid), 64'h0);
    chk("rst_hold_gnt", 64'(gnt), 64'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(4'b1001, 4'b0000, 4'b0001, "post_rst_rr0");
    drive(4'b1000, 4'b0000, 4'b1000, "post_rst_p3");
    req = '0;
    @(posedge clk); #1;

    chk("protocol", 64'(proto_err), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
